// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the fetch address and holds one fetched word for decode.
// Optional out-of-range fetch fault is enabled with `define FETCH_FAULT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] iAddr,
  input  logic [15:0] iDataIn,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  output logic [15:0] instOut,
  output logic [15:0] instPc,
  output logic        instValid,
  input  logic        instReady,
  output logic        fault
);

  typedef enum logic [0:0] {StRun, StFault} stateT;

  stateT       state;
  logic [15:0] pc;
  logic        slotFree;

  // The slot frees up whenever it is empty or decode is taking the word this cycle.
  assign slotFree = !instValid || instReady;
  assign iAddr    = pc;

`ifdef FETCH_FAULT_EN
  logic faultQ;
  logic pcOutOfRange;

  assign pcOutOfRange = (pc[15:10] != 6'd0);
  assign fault        = faultQ;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      instValid <= 1'b0;
      instOut   <= 16'h0000;
      instPc    <= 16'h0000;
      state     <= StRun;
`ifdef FETCH_FAULT_EN
      faultQ    <= 1'b0;
`endif
    end else if (redirect) begin
      // Any word accepted this same cycle is decode's to squash.
      pc        <= redirectPc;
      instValid <= 1'b0;
      state     <= StRun;
`ifdef FETCH_FAULT_EN
      faultQ    <= 1'b0;
`endif
    end else begin
      case (state)
        StRun: begin
          if (slotFree) begin
`ifdef FETCH_FAULT_EN
            if (pcOutOfRange) begin
              state     <= StFault;
              faultQ    <= 1'b1;
              instValid <= 1'b0;
            end else
`endif
            begin
              instOut   <= iDataIn;
              instPc    <= pc;
              instValid <= 1'b1;
              pc        <= pc + 16'd1;
            end
          end
        end
        StFault: begin
          // Frozen until redirect or reset.
        end
        default: state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit with a word-addressed memory model and an
// in-order expected-stream reference.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] iAddr;
  logic [15:0] iDataIn;
  logic        redirect;
  logic [15:0] redirectPc;
  logic [15:0] instOut;
  logic [15:0] instPc;
  logic        instValid;
  logic        instReady;
  logic        fault;

  logic [15:0] mem [1024];

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  assign iDataIn = mem[iAddr[9:0]];

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .iAddr     (iAddr),
    .iDataIn   (iDataIn),
    .redirect  (redirect),
    .redirectPc(redirectPc),
    .instOut   (instOut),
    .instPc    (instPc),
    .instValid (instValid),
    .instReady (instReady),
    .fault     (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectInst(input string tag, input logic [15:0] pcExp);
    check({tag, ".valid"}, {31'd0, instValid}, 32'd1);
    check({tag, ".pc"}, {16'd0, instPc}, {16'd0, pcExp});
    check({tag, ".inst"}, {16'd0, instOut}, {16'd0, mem[pcExp[9:0]]});
  endtask

  logic [15:0] oldWord;
  logic [15:0] expNext;
  logic        preValid, preReady, preRedirect;
  logic [15:0] preOut, prePc, preTarget;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 16'($urandom);
    mem[0] <= 16'h1111;
    mem[1] <= 16'h2222;
    mem[2] <= 16'h3333;
    mem[3] <= 16'h4444;
    reset      = 1'b1;
    redirect   = 1'b0;
    redirectPc = 16'h0000;
    instReady  = 1'b1;

    step();
    step();
    check("rst.valid", {31'd0, instValid}, 32'd0);
    check("rst.inst", {16'd0, instOut}, 32'h0);
    check("rst.pc", {16'd0, instPc}, 32'h0);
    check("rst.iAddr", {16'd0, iAddr}, 32'h0);
    check("rst.fault", {31'd0, fault}, 32'd0);

    // First word one cycle after reset release, then one per cycle.
    reset = 1'b0;
    step();
    check("seq0.inst", {16'd0, instOut}, 32'h1111);
    check("seq0.pc", {16'd0, instPc}, 32'h0);
    check("seq0.valid", {31'd0, instValid}, 32'd1);
    check("seq0.iAddr", {16'd0, iAddr}, 32'h1);
    step();
    check("seq1.inst", {16'd0, instOut}, 32'h2222);

    instReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.inst", {16'd0, instOut}, 32'h2222);
      check("stall.pc", {16'd0, instPc}, 32'h1);
      check("stall.iAddr", {16'd0, iAddr}, 32'h2);
    end
    instReady = 1'b1;
    check("unstall.inst", {16'd0, instOut}, 32'h2222);
    step();
    check("unstall.next", {16'd0, instOut}, 32'h3333);
    check("unstall.pc", {16'd0, instPc}, 32'h2);

    // Redirect costs exactly one bubble.
    redirect   = 1'b1;
    redirectPc = 16'h0100;
    step();
    redirect = 1'b0;
    check("redir.bubble", {31'd0, instValid}, 32'd0);
    check("redir.iAddr", {16'd0, iAddr}, 32'h0100);
    step();
    expectInst("redir.tgt", 16'h0100);
    step();
    expectInst("redir.tgt1", 16'h0101);

    // Fetch in the cycle of a data-port write sees the old word.
    redirect   = 1'b1;
    redirectPc = 16'h0004;
    step();
    redirect = 1'b0;
    step();
    check("wr.iAddr", {16'd0, iAddr}, 32'h5);
    oldWord = mem[5];
    @(posedge clk);
    mem[5] <= 16'hABCD;
    #1;
    check("wr.oldpc", {16'd0, instPc}, 32'h5);
    check("wr.old", {16'd0, instOut}, {16'd0, oldWord});
    redirect   = 1'b1;
    redirectPc = 16'h0005;
    step();
    redirect = 1'b0;
    step();
    check("wr.new", {16'd0, instOut}, 32'hABCD);

    // Back-to-back redirects: last one wins.
    redirect   = 1'b1;
    redirectPc = 16'h0200;
    step();
    check("b2b.v0", {31'd0, instValid}, 32'd0);
    redirectPc = 16'h0300;
    step();
    check("b2b.v1", {31'd0, instValid}, 32'd0);
    redirect = 1'b0;
    step();
    expectInst("b2b.tgt", 16'h0300);

    redirect   = 1'b1;
    redirectPc = 16'h03FE;
    step();
    redirect = 1'b0;
    step();
    expectInst("edge.3fe", 16'h03FE);
    step();
    expectInst("edge.3ff", 16'h03FF);
    step();
`ifdef FETCH_FAULT_EN
    check("flt.fault", {31'd0, fault}, 32'd1);
    check("flt.valid", {31'd0, instValid}, 32'd0);
    check("flt.iAddr", {16'd0, iAddr}, 32'h0400);
    step();
    check("flt.hold", {16'd0, iAddr}, 32'h0400);
    check("flt.sticky", {31'd0, fault}, 32'd1);
    redirect   = 1'b1;
    redirectPc = 16'h0000;
    step();
    redirect = 1'b0;
    check("flt.clear", {31'd0, fault}, 32'd0);
    step();
    check("flt.resume", {16'd0, instOut}, 32'h1111);
    check("flt.resumepc", {16'd0, instPc}, 32'h0);
`else
    check("alias.pc", {16'd0, instPc}, 32'h0400);
    check("alias.inst", {16'd0, instOut}, 32'h1111);
    check("alias.fault", {31'd0, fault}, 32'd0);
    redirect   = 1'b1;
    redirectPc = 16'hFFFF;
    step();
    redirect = 1'b0;
    step();
    expectInst("wrap.ffff", 16'hFFFF);
    step();
    check("wrap.pc0", {16'd0, instPc}, 32'h0);
    check("wrap.iAddr", {16'd0, iAddr}, 32'h1);
`endif

    // Reset during a stall.
    instReady = 1'b0;
    step();
    check("rststall.pre", {31'd0, instValid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rststall.valid", {31'd0, instValid}, 32'd0);
    check("rststall.fault", {31'd0, fault}, 32'd0);
    check("rststall.iAddr", {16'd0, iAddr}, 32'h0);
    instReady = 1'b1;

    // Random phase: every delivered word must follow the expected in-order address stream.
    redirect   = 1'b1;
    redirectPc = 16'h0040;
    expNext    = 16'h0040;
    step();
    redirect = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      preValid    = instValid;
      preReady    = instReady;
      preOut      = instOut;
      prePc       = instPc;
      preRedirect = redirect;
      preTarget   = redirectPc;
      step();
      if (preRedirect) begin
        check("rnd.bubble", {31'd0, instValid}, 32'd0);
        check("rnd.iAddr", {16'd0, iAddr}, {16'd0, preTarget});
        expNext = preTarget;
      end else if (preValid && !preReady) begin
        check("rnd.holdinst", {16'd0, instOut}, {16'd0, preOut});
        check("rnd.holdpc", {16'd0, instPc}, {16'd0, prePc});
      end else begin
        expectInst("rnd.next", expNext);
        expNext = expNext + 16'd1;
      end
      instReady  = ($urandom_range(0, 9) < 7);
      redirect   = ($urandom_range(0, 19) == 0);
      redirectPc = 16'($urandom_range(0, 16'h00FF));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
